fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Sits directly upstream of the decode-stage control. It owns the PC and drives requests to the instruction memory. It buffers returned words in a small in-order prefetch queue and loads the IF/ID register (`Instr_D`, `PC_D`). Redirects are computed from the decode-stage `NPCOp`/`PCWr` of the control block; there is no delay slot, so wrong-path fetches are discarded.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC after reset.
- `QDEPTH`, default 2: prefetch queue depth, which is also the maximum number of outstanding memory requests.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `NPCOp`  in  2: 0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR (from control, decode stage).
- `br_taken`  in  1: branch comparator result for the instruction in D.
- `jr_target`  in  32: bypassed rs value for JR.
- `PCWr`  in  1: PC/redirect enable (0 = decode stalled).
- `pipeRegWr_F`  in  1: IF/ID load enable.
- `im_req`  out  1: fetch request valid.
- `im_addr`  out  32: word address (bits 1:0 = 0).
- `im_gnt`  in  1: request accepted this cycle.
- `im_rvalid`  in  1: response valid; responses return in request order, latency ≥1 cycle.
- `im_rdata`  in  32: response instruction.
- `Instr_D`  out  32: IF/ID instruction (32'h0 = NOP bubble).
- `PC_D`  out  32: PC of `Instr_D`.
- `valid_D`  out  1: `Instr_D` is a real instruction.
- `q_empty`  out  1: queue empty status.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `rsp_pc`: PC of the next live response.
  - `live_cnt`: outstanding requests on the correct path.
  - `drop_cnt`: outstanding wrong-path requests.
  - Queue of {instr, pc}, with count `q_cnt`.
- `redirect = PCWr && valid_D && (NPCOp==2 || NPCOp==3 || (NPCOp==1 && br_taken))`.
- Redirect target:
  - BRANCH: PC_D+4+(sext(Instr_D[15:0])<<2).
  - JUMP: {PC_D[31:28], Instr_D[25:0], 2'b00}.
  - JR: jr_target.
  - All arithmetic is 32-bit modulo; wrap-around is allowed.
- Request:
  - `im_req = !redirect && (live_cnt+drop_cnt) < QDEPTH && (live_cnt+q_cnt) < QDEPTH`.
  - `im_addr = pc`.
  - On `im_req && im_gnt`: pc += 4, and `live_cnt` increments unless a response retires in the same cycle.
- Response:
  - If `drop_cnt > 0`: the word is discarded and `drop_cnt` decrements.
  - Otherwise it is live: `live_cnt` decrements, {im_rdata, rsp_pc} goes to the queue (or bypasses, see below), and rsp_pc += 4.
- Redirect cycle:
  - pc ← target; rsp_pc ← target.
  - Queue cleared.
  - `drop_cnt ← drop_cnt + live_cnt`, minus 1 if a response arrives this cycle.
  - `live_cnt ← 0`.
  - A response arriving in the redirect cycle is discarded.
  - IF/ID loads a bubble: valid_D=0, Instr_D=0, PC_D unchanged.
- IF/ID load when `pipeRegWr_F && !redirect`:
  - Queue non-empty: load the head and pop it.
  - Queue empty and live response this cycle: bypass the response directly into IF/ID.
  - Otherwise: load a bubble (valid_D=0, Instr_D=0).
- When `pipeRegWr_F=0`: IF/ID holds its value; the queue still accepts responses. The credit rule guarantees no overflow.
- A push and a pop in the same cycle leave `q_cnt` unchanged.
- A response can never arrive when `live_cnt+drop_cnt==0`. If it does, it is ignored (verification flags it as an assertion).

## Timing
- Reset values:
  - pc=rsp_pc=RESET_PC, PC_D=RESET_PC.
  - Instr_D=0, valid_D=0.
  - live_cnt=drop_cnt=q_cnt=0, q_empty=1.
  - im_req=1 in the first cycle after reset release; im_addr=RESET_PC.
- Asserting rst_n mid-operation clears all state immediately. Responses arriving after reset release belong to requests that never existed and are not tracked.
- Memory with 1-cycle latency and `im_gnt`=1:
  - Request in cycle N, response in N+1, instruction visible on `Instr_D` in N+2.
  - Steady-state throughput is 1 instruction per cycle.
- Redirect in cycle R:
  - Target request in R+1, response in R+2, target instruction on `Instr_D` in R+3.
  - Penalty is 2 bubbles: valid_D=0 in R+1 and R+2.
- `im_req` must be held by the requester until `im_gnt`; `im_addr` is stable while waiting. A redirect withdraws the request (the only allowed withdrawal).

## Test plan
- Reset release, memory latency 1, gnt always 1, pipeRegWr_F=1 -> valid_D rises 2 cycles after the first request; PC_D follows 3000, 3004, 3008 on consecutive cycles.
- pipeRegWr_F=0 for 3 cycles mid-stream -> Instr_D/PC_D hold; im_req drops once live_cnt+q_cnt=2; no word is lost or duplicated after release.
- BEQ at PC_D=3008, imm16=16'hFFFE, br_taken=1 -> next valid PC_D=3004 exactly 3 cycles later; words from 300C/3010 never appear on Instr_D.
- JR, jr_target=32'h0000_4000, with 2 requests in flight at latency 3 -> drop_cnt=2; both stale words are discarded; first valid PC_D=4000.
- A response arriving in the same cycle as a JUMP redirect -> the response is discarded; drop_cnt counts correctly; no stale word appears on Instr_D.
- rst_n pulsed low while the queue is full -> all outputs return to reset values within the same cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the fetch PC, issues in-order word requests to instruction memory,
// buffers returned words in a small prefetch queue and loads the IF/ID
// register. Decode-stage redirects (branch/jump/jr) discard wrong-path
// words: outstanding requests are moved to a drop counter and their
// responses are thrown away as they return.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   NPCOp, br_taken      decode-stage next-PC selection and branch outcome
//   jr_target            bypassed rs value for JR
//   PCWr                 redirect enable (0 = decode stalled)
//   pipeRegWr_F          IF/ID load enable
//   im_req/im_addr       fetch request and word address
//   im_gnt               request accepted this cycle
//   im_rvalid/im_rdata   in-order response
//   Instr_D/PC_D/valid_D IF/ID register contents
//   q_empty              prefetch queue empty
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  NPCOp,
    input  logic        br_taken,
    input  logic [31:0] jr_target,
    input  logic        PCWr,
    input  logic        pipeRegWr_F,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic        valid_D,
    output logic        q_empty
);
    localparam int            CW       = $clog2(QDEPTH + 1);
    localparam int            PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(QDEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_live_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_q_cnt;
    logic [PW-1:0] r_q_head;
    logic [PW-1:0] r_q_tail;
    logic [31:0]   r_q_instr [QDEPTH];
    logic [31:0]   r_q_pc    [QDEPTH];
    logic [31:0]   r_instr_d;
    logic [31:0]   r_pc_d;
    logic          r_valid_d;

    logic          w_redirect;
    logic [31:0]   w_target;
    logic [31:0]   w_br_off;
    logic [CW:0]   w_inflight;
    logic [CW:0]   w_credit;
    logic          w_fire;
    logic          w_rsp_any;
    logic          w_rsp_drop;
    logic          w_rsp_live;
    logic          w_load;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;

    // Circular queue pointer advance; depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == LAST_PTR) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    assign w_redirect = PCWr && r_valid_d &&
                        ((NPCOp == 2'd2) || (NPCOp == 2'd3) || ((NPCOp == 2'd1) && br_taken));

    // Redirect target from the instruction currently held in IF/ID.
    always_comb begin
        w_br_off = {{14{r_instr_d[15]}}, r_instr_d[15:0], 2'b00};
        case (NPCOp)
            2'd1:    w_target = r_pc_d + 32'd4 + w_br_off;
            2'd2:    w_target = {r_pc_d[31:28], r_instr_d[25:0], 2'b00};
            2'd3:    w_target = jr_target;
            default: w_target = r_pc_d + 32'd4;
        endcase
    end

    // Two credits: total outstanding bounded by QDEPTH, and every live
    // request must have a queue slot waiting for it so pushes never overflow.
    assign w_inflight = {1'b0, r_live_cnt} + {1'b0, r_drop_cnt};
    assign w_credit   = {1'b0, r_live_cnt} + {1'b0, r_q_cnt};
    assign im_req     = !w_redirect && (w_inflight < DEPTH_C) && (w_credit < DEPTH_C);
    assign im_addr    = r_pc;
    assign w_fire     = im_req && im_gnt;

    // A response with nothing outstanding is spurious and ignored.
    assign w_rsp_any  = im_rvalid && (w_inflight != {(CW + 1){1'b0}});
    assign w_rsp_drop = w_rsp_any && (r_drop_cnt != CNT_ZERO);
    assign w_rsp_live = w_rsp_any && (r_drop_cnt == CNT_ZERO) && !w_redirect;

    assign w_load   = pipeRegWr_F && !w_redirect;
    assign w_pop    = w_load && (r_q_cnt != CNT_ZERO);
    assign w_bypass = w_load && (r_q_cnt == CNT_ZERO) && w_rsp_live;
    assign w_push   = w_rsp_live && !w_bypass;

    // Fetch PC, response PC and live/drop outstanding counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_live_cnt <= CNT_ZERO;
            r_drop_cnt <= CNT_ZERO;
        end else if (w_redirect) begin
            r_pc       <= w_target;
            r_rsp_pc   <= w_target;
            r_live_cnt <= CNT_ZERO;
            // Every live request becomes wrong-path; one retiring now is gone.
            r_drop_cnt <= r_drop_cnt + r_live_cnt - CW'(w_rsp_any);
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_rsp_live) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            r_live_cnt <= r_live_cnt + CW'(w_fire) - CW'(w_rsp_live);
            r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop);
        end
    end

    // Prefetch queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_head <= {PW{1'b0}};
            r_q_tail <= {PW{1'b0}};
            r_q_cnt  <= CNT_ZERO;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= 32'h0000_0000;
                r_q_pc[i]    <= 32'h0000_0000;
            end
        end else if (w_redirect) begin
            r_q_head <= {PW{1'b0}};
            r_q_tail <= {PW{1'b0}};
            r_q_cnt  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_q_instr[r_q_tail] <= im_rdata;
                r_q_pc[r_q_tail]    <= r_rsp_pc;
                r_q_tail            <= ptr_inc(r_q_tail);
            end
            if (w_pop) begin
                r_q_head <= ptr_inc(r_q_head);
            end
            r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // IF/ID register: queue head first, then direct bypass, else bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_d <= 32'h0000_0000;
            r_pc_d    <= RESET_PC;
            r_valid_d <= 1'b0;
        end else if (w_redirect) begin
            r_instr_d <= 32'h0000_0000;
            r_valid_d <= 1'b0;
        end else if (pipeRegWr_F) begin
            if (w_pop) begin
                r_instr_d <= r_q_instr[r_q_head];
                r_pc_d    <= r_q_pc[r_q_head];
                r_valid_d <= 1'b1;
            end else if (w_bypass) begin
                r_instr_d <= im_rdata;
                r_pc_d    <= r_rsp_pc;
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= 32'h0000_0000;
                r_valid_d <= 1'b0;
            end
        end
    end

    assign Instr_D = r_instr_d;
    assign PC_D    = r_pc_d;
    assign valid_D = r_valid_d;
    assign q_empty = (r_q_cnt == CNT_ZERO);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// The bench plays instruction memory (in-order, programmable latency and
// grant pattern) and the decode-stage control. An architectural model
// predicts the program-order PC stream: each real instruction reaching
// IF/ID must be the successor of the previous one (PC+4, or the redirect
// target), carry the memory word at its PC, and stalls must hold IF/ID.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          QD     = 2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  NPCOp;
    logic        br_taken;
    logic [31:0] jr_target;
    logic        PCWr;
    logic        pipeRegWr_F;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic        valid_D;
    logic        q_empty;

    fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .NPCOp(NPCOp), .br_taken(br_taken),
        .jr_target(jr_target), .PCWr(PCWr), .pipeRegWr_F(pipeRegWr_F),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata), .Instr_D(Instr_D),
        .PC_D(PC_D), .valid_D(valid_D), .q_empty(q_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int          lat;
    int          last_due;
    bit          gnt_alt;
    bit          stall;
    bit          beq_take;
    bit          hold_pend;
    logic [31:0] hold_addr;
    logic [31:0] jr_tgt;
    logic [31:0] exp_next_pc;
    req_t        pend[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Program image: BEQ at 3008 (back to 3004), JR at 3020, J at 4020 -> 5000.
    function automatic logic [31:0] prog_word(input logic [31:0] a);
        case (a)
            32'h0000_3008: return 32'h1000_FFFE;
            32'h0000_3020: return 32'h03E0_0008;
            32'h0000_4020: return 32'h0800_1400;
            default:       return {6'b001000, 10'd0, a[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] model_target(input logic [1:0] op, input logic [31:0] pc,
                                                 input logic [31:0] ins, input logic [31:0] jr);
        int off;
        off = int'($signed(ins[15:0])) * 4;
        case (op)
            2'd1:    return pc + 32'd4 + 32'(off);
            2'd2:    return (pc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
            2'd3:    return jr;
            default: return pc + 32'd4;
        endcase
    endfunction

    // Memory responses, grant pattern and decode-stage control for this cycle.
    task automatic drive_inputs();
        if (pend.size() > 0 && pend[0].due == cyc) begin
            im_rvalid = 1'b1;
            im_rdata  = prog_word(pend[0].addr);
            pend.delete(0);
        end else begin
            im_rvalid = 1'b0;
            im_rdata  = $urandom();
        end
        im_gnt      = gnt_alt ? ((cyc % 2) == 1) : 1'b1;
        pipeRegWr_F = !stall;
        PCWr        = 1'b1;
        br_taken    = beq_take;
        jr_target   = jr_tgt;
        if (valid_D && Instr_D[31:26] == 6'h04) NPCOp = 2'd1;
        else if (valid_D && Instr_D[31:26] == 6'h02) NPCOp = 2'd2;
        else if (valid_D && Instr_D[31:26] == 6'h00 && Instr_D[5:0] == 6'h08) NPCOp = 2'd3;
        else NPCOp = 2'd0;
    endtask

    // One clock cycle: sample pre-edge, clock, check against the model, drive.
    task automatic cycle();
        logic        p_valid, p_load, p_req, p_gnt, p_redir;
        logic [1:0]  p_op;
        logic [31:0] p_instr, p_pc, p_addr, tgt;
        req_t        r;
        #1;
        p_valid = valid_D;  p_instr = Instr_D;  p_pc = PC_D;
        p_load  = pipeRegWr_F;  p_req = im_req;  p_gnt = im_gnt;
        p_addr  = im_addr;  p_op = NPCOp;
        p_redir = PCWr && p_valid && (p_op == 2'd2 || p_op == 2'd3 || (p_op == 2'd1 && br_taken));
        tgt     = model_target(p_op, p_pc, p_instr, jr_target);
        chk("addr_align", {30'd0, p_addr[1:0]}, 32'd0);
        if (hold_pend && !p_redir) begin
            chk("req_hold", {31'd0, p_req}, 32'd1);
            chk("addr_hold", p_addr, hold_addr);
        end
        if (p_redir) chk("req_withdraw", {31'd0, p_req}, 32'd0);
        hold_pend = p_req && !p_gnt;
        hold_addr = p_addr;
        if (p_req && p_gnt) begin
            r.addr = p_addr;
            r.due  = cyc + lat;
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            pend.push_back(r);
            chk("outstanding_bound", {31'd0, (pend.size() <= QD)}, 32'd1);
        end
        if (p_redir && p_op == 2'd1) beq_take = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (p_redir) begin
            chk("redir_bubble_valid", {31'd0, valid_D}, 32'd0);
            chk("redir_bubble_instr", Instr_D, 32'd0);
            chk("redir_pc_hold", PC_D, p_pc);
            exp_next_pc = tgt;
        end else if (p_load) begin
            if (p_valid) exp_next_pc = p_pc + 32'd4;
            if (valid_D) begin
                chk("seq_pc", PC_D, exp_next_pc);
                chk("seq_instr", Instr_D, prog_word(PC_D));
            end else begin
                chk("bubble_instr", Instr_D, 32'd0);
            end
        end else begin
            chk("stall_valid", {31'd0, valid_D}, {31'd0, p_valid});
            chk("stall_instr", Instr_D, p_instr);
            chk("stall_pc", PC_D, p_pc);
        end
        drive_inputs();
    endtask

    task automatic run_to(input logic [31:0] target, input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            if (valid_D && PC_D == target) found = 1'b1;
        end
        chk(name, {31'd0, found}, 32'd1);
    endtask

    // Assert reset (asynchronously), check outputs, then release mid-cycle.
    task automatic apply_reset();
        rst_n = 1'b0;
        pend.delete();
        hold_pend   = 1'b0;
        exp_next_pc = RST_PC;
        beq_take    = 1'b1;
        stall       = 1'b0;
        gnt_alt     = 1'b0;
        lat         = 1;
        last_due    = -1;
        cyc         = 0;
        im_rvalid   = 1'b0;
        im_rdata    = 32'd0;
        im_gnt      = 1'b1;
        pipeRegWr_F = 1'b1;
        PCWr        = 1'b1;
        NPCOp       = 2'd0;
        br_taken    = 1'b0;
        jr_target   = jr_tgt;
        #1;
        chk("rst_valid", {31'd0, valid_D}, 32'd0);
        chk("rst_instr", Instr_D, 32'd0);
        chk("rst_pc_d", PC_D, RST_PC);
        chk("rst_q_empty", {31'd0, q_empty}, 32'd1);
        chk("rst_im_addr", im_addr, RST_PC);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // First request right after release; first instruction two cycles later.
    task automatic startup_checks();
        #1;
        chk("boot_req", {31'd0, im_req}, 32'd1);
        chk("boot_addr", im_addr, RST_PC);
        cycle();
        chk("boot_c1_valid", {31'd0, valid_D}, 32'd0);
        cycle();
        chk("boot_c2_valid", {31'd0, valid_D}, 32'd1);
        chk("boot_c2_pc", PC_D, 32'h0000_3000);
        cycle();
        chk("boot_c3_pc", PC_D, 32'h0000_3004);
        cycle();
        chk("boot_c4_pc", PC_D, 32'h0000_3008);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rst_n  = 1'b1;
        jr_tgt = 32'h0000_4000;
        #2;
        apply_reset();
        startup_checks();

        // BEQ at 3008 taken back to 3004: two bubbles, target on the third cycle.
        cycle();
        chk("beq_r1_valid", {31'd0, valid_D}, 32'd0);
        cycle();
        chk("beq_r2_valid", {31'd0, valid_D}, 32'd0);
        cycle();
        chk("beq_r3_valid", {31'd0, valid_D}, 32'd1);
        chk("beq_r3_pc", PC_D, 32'h0000_3004);

        // Three-cycle IF/ID stall at 3010.
        run_to(32'h0000_3010, 20, "reach_3010");
        stall = 1'b1;
        pipeRegWr_F = 1'b0;
        cycle();
        cycle();
        #1;
        chk("stall_req_drop", {31'd0, im_req}, 32'd0);
        chk("stall_q_nonempty", {31'd0, q_empty}, 32'd0);
        chk("stall_pc_held", PC_D, 32'h0000_3010);
        cycle();
        stall = 1'b0;
        pipeRegWr_F = 1'b1;

        // JR to 4000 with latency-3 memory, two requests in flight.
        lat = 3;
        run_to(32'h0000_3020, 40, "reach_jr");
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (valid_D) found = 1'b1;
        end
        chk("jr_found", {31'd0, found}, 32'd1);
        chk("jr_first_pc", PC_D, 32'h0000_4000);

        // J at 4020 with a response landing in the redirect cycle.
        lat = 1;
        run_to(32'h0000_4020, 40, "reach_j");
        chk("j_rsp_same_cycle", {31'd0, im_rvalid}, 32'd1);
        cycle();
        chk("j_r1_valid", {31'd0, valid_D}, 32'd0);
        cycle();
        chk("j_r2_valid", {31'd0, valid_D}, 32'd0);
        cycle();
        chk("j_r3_valid", {31'd0, valid_D}, 32'd1);
        chk("j_r3_pc", PC_D, 32'h0000_5000);

        // Grant only every other cycle: requests must be held stable.
        gnt_alt = 1'b1;
        repeat (16) cycle();
        gnt_alt = 1'b0;
        chk("gnt_alt_progress", {31'd0, (PC_D >= 32'h0000_5010)}, 32'd1);
        repeat (4) cycle();

        // Fill the queue under stall, then pulse reset mid-cycle.
        stall = 1'b1;
        pipeRegWr_F = 1'b0;
        repeat (3) cycle();
        #1;
        chk("full_q_nonempty", {31'd0, q_empty}, 32'd0);
        chk("full_req_low", {31'd0, im_req}, 32'd0);
        #1;
        apply_reset();
        startup_checks();
        repeat (6) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
